// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 5-stage MIPS pipeline.
//   Owns the PC, drives the instruction-memory address and loads the
//   IF/ID pipeline register. Applies hazard stalls, EX branch redirects
//   and ID jump redirects, and keeps fetch/bubble counters.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   stall             hold PC and IF/ID (load-use hazard)
//   br_redirect/target  EX taken branch: squash IF/ID, jump PC
//   jmp_redirect/target ID jump: squash IF/ID, jump PC
//   imem_addr/data    instruction memory (data combinational from addr)
//   if_id_instr/pc4/valid  IF/ID pipeline register
//   state             0 RUN, 1 STALL, 2 SQUASH (kind of last update)
//   fetch_count       real instructions loaded into IF/ID since reset
//   bubble_count      NOPs inserted by squashes since reset
module fetch_stage #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [31:0]           NOP_INSTR  = 32'h00000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  br_redirect,
    input  logic [ADDR_WIDTH-1:0] br_target,
    input  logic                  jmp_redirect,
    input  logic [ADDR_WIDTH-1:0] jmp_target,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_data,
    output logic [31:0]           if_id_instr,
    output logic [ADDR_WIDTH-1:0] if_id_pc4,
    output logic                  if_id_valid,
    output logic [1:0]            state,
    output logic [31:0]           fetch_count,
    output logic [31:0]           bubble_count
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_SQUASH = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] FOUR       = ADDR_WIDTH'(4);
    // Redirect targets are forced word-aligned; stray low bits are dropped.
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    state_t                st;

    assign imem_addr = pc;
    assign pc_plus4  = pc + FOUR;   // wraps modulo 2^ADDR_WIDTH
    assign state     = st;

    // Priority: reset > br_redirect > stall > jmp_redirect > sequential.
    // The branch beats stall because EX is older than the stalled ID
    // instruction; a jump under stall is re-asserted by the held ID entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RESET_PC;
            if_id_instr  <= NOP_INSTR;
            if_id_pc4    <= '0;
            if_id_valid  <= 1'b0;
            st           <= ST_RUN;
            fetch_count  <= '0;
            bubble_count <= '0;
        end else if (br_redirect) begin
            pc           <= br_target & ALIGN_MASK;
            if_id_instr  <= NOP_INSTR;
            if_id_pc4    <= '0;
            if_id_valid  <= 1'b0;
            st           <= ST_SQUASH;
            bubble_count <= bubble_count + 32'd1;
        end else if (stall) begin
            st <= ST_STALL;
        end else if (jmp_redirect) begin
            // No delay slot: the word fetched this cycle is discarded.
            pc           <= jmp_target & ALIGN_MASK;
            if_id_instr  <= NOP_INSTR;
            if_id_pc4    <= '0;
            if_id_valid  <= 1'b0;
            st           <= ST_SQUASH;
            bubble_count <= bubble_count + 32'd1;
        end else begin
            pc           <= pc_plus4;
            if_id_instr  <= imem_data;
            if_id_pc4    <= pc_plus4;
            if_id_valid  <= 1'b1;
            st           <= ST_RUN;
            fetch_count  <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: table-driven vectors for stall/redirect
// behaviour plus hand sequences for reset-under-stall and PC wrap.
module tb_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (RESET_PC = 0)
    logic        reset, stall, br_redirect, jmp_redirect;
    logic [31:0] br_target, jmp_target, imem_addr, imem_data;
    logic [31:0] if_id_instr, if_id_pc4, fetch_count, bubble_count;
    logic        if_id_valid;
    logic [1:0]  state;

    // Wrap DUT (RESET_PC = 0xFFFFFFFC)
    logic        reset_w;
    logic [31:0] imem_addr_w, imem_data_w, if_id_instr_w, if_id_pc4_w;
    logic [31:0] fetch_count_w, bubble_count_w;
    logic        if_id_valid_w;
    logic [1:0]  state_w;

    int ntests = 0;
    int nfail  = 0;

    // imem[k] = k + 0x100 (k = word index)
    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'h100 + (a >> 2);
    endfunction

    assign imem_data   = mem(imem_addr);
    assign imem_data_w = mem(imem_addr_w);

    fetch_stage dut (
        .clk(clk), .reset(reset), .stall(stall),
        .br_redirect(br_redirect), .br_target(br_target),
        .jmp_redirect(jmp_redirect), .jmp_target(jmp_target),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
        .if_id_valid(if_id_valid), .state(state),
        .fetch_count(fetch_count), .bubble_count(bubble_count)
    );

    fetch_stage #(.RESET_PC(32'hFFFFFFFC)) dut_w (
        .clk(clk), .reset(reset_w), .stall(1'b0),
        .br_redirect(1'b0), .br_target(32'h0),
        .jmp_redirect(1'b0), .jmp_target(32'h0),
        .imem_addr(imem_addr_w), .imem_data(imem_data_w),
        .if_id_instr(if_id_instr_w), .if_id_pc4(if_id_pc4_w),
        .if_id_valid(if_id_valid_w), .state(state_w),
        .fetch_count(fetch_count_w), .bubble_count(bubble_count_w)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_addr, input logic [31:0] e_instr,
                           input logic [31:0] e_pc4, input logic e_valid, input logic [1:0] e_state,
                           input logic [31:0] e_fc, input logic [31:0] e_bc);
        chk({tag, ".imem_addr"},    imem_addr,           e_addr);
        chk({tag, ".if_id_instr"},  if_id_instr,         e_instr);
        chk({tag, ".if_id_pc4"},    if_id_pc4,           e_pc4);
        chk({tag, ".if_id_valid"},  {31'h0, if_id_valid}, {31'h0, e_valid});
        chk({tag, ".state"},        {30'h0, state},      {30'h0, e_state});
        chk({tag, ".fetch_count"},  fetch_count,         e_fc);
        chk({tag, ".bubble_count"}, bubble_count,        e_bc);
    endtask

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] br_t;
        logic        jmp;
        logic [31:0] jmp_t;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
        logic [1:0]  e_state;
        logic [31:0] e_fc;
        logic [31:0] e_bc;
    } vec_t;

    localparam logic [1:0] RUN = 2'd0, STL = 2'd1, SQ = 2'd2;
    localparam int NV = 15;
    vec_t vec [NV];

    initial begin
        //            stall br   br_t   jmp  jmp_t   addr   instr  pc4    v    st   fc  bc
        vec[0]  = '{1'b0,1'b0,32'h0, 1'b0,32'h0,  32'h04,32'h100,32'h04,1'b1,RUN,32'd1,32'd0};
        vec[1]  = '{1'b0,1'b0,32'h0, 1'b0,32'h0,  32'h08,32'h101,32'h08,1'b1,RUN,32'd2,32'd0};
        vec[2]  = '{1'b1,1'b0,32'h0, 1'b0,32'h0,  32'h08,32'h101,32'h08,1'b1,STL,32'd2,32'd0};
        vec[3]  = '{1'b1,1'b0,32'h0, 1'b0,32'h0,  32'h08,32'h101,32'h08,1'b1,STL,32'd2,32'd0};
        vec[4]  = '{1'b1,1'b0,32'h0, 1'b0,32'h0,  32'h08,32'h101,32'h08,1'b1,STL,32'd2,32'd0};
        vec[5]  = '{1'b0,1'b0,32'h0, 1'b0,32'h0,  32'h0C,32'h102,32'h0C,1'b1,RUN,32'd3,32'd0};
        vec[6]  = '{1'b0,1'b0,32'h0, 1'b0,32'h0,  32'h10,32'h103,32'h10,1'b1,RUN,32'd4,32'd0};
        // branch beats stall
        vec[7]  = '{1'b1,1'b1,32'h40,1'b0,32'h0,  32'h40,32'h0,  32'h0, 1'b0,SQ, 32'd4,32'd1};
        vec[8]  = '{1'b0,1'b0,32'h0, 1'b0,32'h0,  32'h44,32'h110,32'h44,1'b1,RUN,32'd5,32'd1};
        // branch beats jump, then jump alone (unaligned target), back-to-back
        vec[9]  = '{1'b0,1'b1,32'h80,1'b1,32'h23, 32'h80,32'h0,  32'h0, 1'b0,SQ, 32'd5,32'd2};
        vec[10] = '{1'b0,1'b0,32'h0, 1'b1,32'h23, 32'h20,32'h0,  32'h0, 1'b0,SQ, 32'd5,32'd3};
        vec[11] = '{1'b0,1'b0,32'h0, 1'b0,32'h0,  32'h24,32'h108,32'h24,1'b1,RUN,32'd6,32'd3};
        // stall drops a jump
        vec[12] = '{1'b1,1'b0,32'h0, 1'b1,32'h60, 32'h24,32'h108,32'h24,1'b1,STL,32'd6,32'd3};
        // unaligned branch target
        vec[13] = '{1'b0,1'b1,32'h33,1'b0,32'h0,  32'h30,32'h0,  32'h0, 1'b0,SQ, 32'd6,32'd4};
        // stall at pc 0x30 holding the bubble (not counted as a fetch)
        vec[14] = '{1'b1,1'b0,32'h0, 1'b0,32'h0,  32'h30,32'h0,  32'h0, 1'b0,STL,32'd6,32'd4};

        reset = 1'b1; reset_w = 1'b1;
        stall = 1'b0; br_redirect = 1'b0; jmp_redirect = 1'b0;
        br_target = '0; jmp_target = '0;
        @(posedge clk); #1;
        chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, RUN, 32'd0, 32'd0);
        chk("wrap.reset_addr", imem_addr_w, 32'hFFFFFFFC);

        @(negedge clk);
        reset = 1'b0; reset_w = 1'b0;
        @(posedge clk); #1;
        chk("wrap.imem_addr",   imem_addr_w,            32'h0);
        chk("wrap.if_id_pc4",   if_id_pc4_w,            32'h0);
        chk("wrap.if_id_valid", {31'h0, if_id_valid_w}, 32'h1);
        chk("wrap.if_id_instr", if_id_instr_w,          32'h400000FF);
        chk("wrap.fetch_count", fetch_count_w,          32'd1);
        chk_all("v0", vec[0].e_addr, vec[0].e_instr, vec[0].e_pc4, vec[0].e_valid,
                vec[0].e_state, vec[0].e_fc, vec[0].e_bc);

        for (int i = 1; i < NV; i++) begin
            @(negedge clk);
            stall        = vec[i].stall;
            br_redirect  = vec[i].br;
            br_target    = vec[i].br_t;
            jmp_redirect = vec[i].jmp;
            jmp_target   = vec[i].jmp_t;
            @(posedge clk); #1;
            chk_all($sformatf("v%0d", i), vec[i].e_addr, vec[i].e_instr, vec[i].e_pc4,
                    vec[i].e_valid, vec[i].e_state, vec[i].e_fc, vec[i].e_bc);
        end

        // Reset asserted mid-stall with a redirect pending: reset wins.
        @(negedge clk);
        reset = 1'b1; stall = 1'b1; br_redirect = 1'b1; br_target = 32'h90;
        jmp_redirect = 1'b0;
        @(posedge clk); #1;
        chk_all("rst_in_stall", 32'h0, 32'h0, 32'h0, 1'b0, RUN, 32'd0, 32'd0);

        // Resume after reset: first fetch from address 0.
        @(negedge clk);
        reset = 1'b0; stall = 1'b0; br_redirect = 1'b0;
        @(posedge clk); #1;
        chk_all("post_rst", 32'h4, 32'h100, 32'h4, 1'b1, RUN, 32'd1, 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
